// File: rtl/ic_gb8_pingpong_buffer.sv
// Double-buffered 8-row stripe store: raster-order writes into one bank while
// the other bank is read out in 8x8 block order through a 2-entry output FIFO.
module ic_gb8_pingpong_buffer #(
  parameter int DATA_W = 32,
  parameter int IMG_W  = 960,
  parameter int ADDR_W = 13
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sof,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sob,
  output logic              out_eob,
  output logic              out_last_block
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int NBLK  = IMG_W / 8;
  localparam int BLK_W = (NBLK > 1) ? $clog2(NBLK) : 1;
  localparam int DEPTH = 8 * IMG_W;
  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [BLK_W-1:0]  BLK_LAST = BLK_W'(NBLK - 1);
  localparam logic [ADDR_W-1:0] IMG_W_A  = ADDR_W'(IMG_W);

  logic              wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic [1:0]        full_q, full_d, full_set, full_clr;
  logic [COL_W-1:0]  wcol_q, wcol_d, wcol_base;
  logic [2:0]        wrow_q, wrow_d, wrow_base;
  logic [BLK_W-1:0]  blk_q, blk_d;
  logic [2:0]        r_q, r_d, c_q, c_d;
  logic              pend_q, pend_d, pend_bank_q, pend_bank_d;
  logic [2:0]        pend_tag_q, pend_tag_d;   // {sob, eob, last_block}
  logic [DATA_W-1:0] fifo_data_q [2];
  logic [DATA_W-1:0] fifo_data_d [2];
  logic [2:0]        fifo_tag_q [2];
  logic [2:0]        fifo_tag_d [2];
  logic              head_q, head_d;
  logic [1:0]        cnt_q, cnt_d, occ;
  logic              wr_acc, rd_issue, pop, push, tail;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [DATA_W-1:0] rd_data;

  assign in_ready = !full_q[wr_bank_q] && !reset;
  assign wr_acc   = in_valid && in_ready;
  assign pop      = out_valid && out_ready;
  assign push     = pend_q;
  assign tail     = head_q ^ cnt_q[0];
  // Counting the current pop lets a read issue every cycle under steady drain.
  assign occ      = cnt_q + {1'b0, pend_q} - {1'b0, pop};
  assign rd_issue = full_q[rd_bank_q] && (occ < 2'd2);

  assign wcol_base = in_sof ? '0 : wcol_q;
  assign wrow_base = in_sof ? '0 : wrow_q;
  assign wr_addr   = ADDR_W'(wrow_base) * IMG_W_A + ADDR_W'(wcol_base);
  assign rd_addr   = ADDR_W'(r_q) * IMG_W_A + (ADDR_W'(blk_q) << 3) + ADDR_W'(c_q);

  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] q;
    logic              we, re;
    logic [ADDR_W-1:0] addr;

    assign we   = wr_acc && (wr_bank_q == 1'(gi));
    assign re   = rd_issue && (rd_bank_q == 1'(gi));
    assign addr = we ? wr_addr : rd_addr;

    always_ff @(posedge clock) begin
      if (we) begin
        mem[addr] <= in_data;
      end else if (re) begin
        q <= mem[addr];
      end
    end
  end

  assign rd_data = pend_bank_q ? g_bank[1].q : g_bank[0].q;

  always_comb begin
    wcol_d    = wcol_q;
    wrow_d    = wrow_q;
    wr_bank_d = wr_bank_q;
    full_set  = 2'b00;
    if (wr_acc) begin
      if (wcol_base == COL_LAST) begin
        wcol_d = '0;
        if (wrow_base == 3'd7) begin
          wrow_d             = 3'd0;
          full_set[wr_bank_q] = 1'b1;
          wr_bank_d          = ~wr_bank_q;
        end else begin
          wrow_d = wrow_base + 3'd1;
        end
      end else begin
        wcol_d = wcol_base + 1'b1;
        wrow_d = wrow_base;
      end
    end
  end

  always_comb begin
    blk_d       = blk_q;
    r_d         = r_q;
    c_d         = c_q;
    rd_bank_d   = rd_bank_q;
    full_clr    = 2'b00;
    pend_d      = rd_issue;
    pend_bank_d = rd_bank_q;
    pend_tag_d  = {(r_q == 3'd0) && (c_q == 3'd0),
                   (r_q == 3'd7) && (c_q == 3'd7),
                   blk_q == BLK_LAST};
    if (rd_issue) begin
      c_d = c_q + 3'd1;
      if (c_q == 3'd7) begin
        r_d = r_q + 3'd1;
        if (r_q == 3'd7) begin
          if (blk_q == BLK_LAST) begin
            blk_d               = '0;
            full_clr[rd_bank_q] = 1'b1;
            rd_bank_d           = ~rd_bank_q;
          end else begin
            blk_d = blk_q + 1'b1;
          end
        end
      end
    end
  end

  assign full_d = (full_q | full_set) & ~full_clr;

  always_comb begin
    fifo_data_d = fifo_data_q;
    fifo_tag_d  = fifo_tag_q;
    if (push) begin
      fifo_data_d[tail] = rd_data;
      fifo_tag_d[tail]  = pend_tag_q;
    end
    head_d = head_q ^ pop;
    cnt_d  = cnt_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      full_q      <= 2'b00;
      wcol_q      <= '0;
      wrow_q      <= '0;
      blk_q       <= '0;
      r_q         <= '0;
      c_q         <= '0;
      pend_q      <= 1'b0;
      pend_bank_q <= 1'b0;
      pend_tag_q  <= '0;
      fifo_data_q <= '{default: '0};
      fifo_tag_q  <= '{default: '0};
      head_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      full_q      <= full_d;
      wcol_q      <= wcol_d;
      wrow_q      <= wrow_d;
      blk_q       <= blk_d;
      r_q         <= r_d;
      c_q         <= c_d;
      pend_q      <= pend_d;
      pend_bank_q <= pend_bank_d;
      pend_tag_q  <= pend_tag_d;
      fifo_data_q <= fifo_data_d;
      fifo_tag_q  <= fifo_tag_d;
      head_q      <= head_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid      = (cnt_q != 2'd0);
  assign out_data       = out_valid ? fifo_data_q[head_q] : '0;
  assign out_sob        = out_valid && fifo_tag_q[head_q][2];
  assign out_eob        = out_valid && fifo_tag_q[head_q][1];
  assign out_last_block = out_valid && fifo_tag_q[head_q][0];

endmodule

// File: doc/ic_gb8_pingpong_buffer.md
# ic_gb8_pingpong_buffer

Parametrised double-buffered stripe store for the get-block-8x8 stage of the JPEG compression path. It accepts raster-order sample words for one 8-row stripe of the image into one bank, while the other bank is read out in 8x8 block order (block by block, row by row within a block) to the DCT front end. It replaces the single-bank 32-bit buffer with a ping-pong pair, so writing and block readout overlap at full throughput, with valid/ready handshakes on both sides.

## Interface
- DATA_W, 32: width of one sample word.
- IMG_W, 960: image width in words; a multiple of 8, at least 16.
- ADDR_W, 13: bank address width; 2^ADDR_W ≥ 8*IMG_W.
- clock  in  1  single clock; all logic rising-edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  write word present.
- in_ready  out  1  word accepted when in_valid && in_ready.
- in_data  in  DATA_W  raster sample word.
- in_sof  in  1  start of frame, qualified by the accept.
- out_valid  out  1  block word present.
- out_ready  in  1  consumer accepts when out_valid && out_ready.
- out_data  out  DATA_W  block-order sample word.
- out_sob  out  1  first word of an 8x8 block.
- out_eob  out  1  64th word of a block.
- out_last_block  out  1  word belongs to the last block of the stripe.

## Operation
- Storage: two single-port synchronous RAMs (bank 0 and bank 1), each 8*IMG_W deep and DATA_W wide. Reads have a 1-cycle latency with unregistered q. A bank is never written and read in the same cycle.
- State: wr_bank, rd_bank (1 bit each), full[1:0], write counters wcol (0..IMG_W-1) and wrow (0..7), read counters blk (0..IMG_W/8-1), r (0..7), c (0..7).
- Write side:
  - in_ready = !full[wr_bank] && !reset.
  - On accept, write in_data to address wrow*IMG_W + wcol of wr_bank.
  - wcol wraps to 0 at IMG_W-1 and increments wrow.
  - On accepting (wrow=7, wcol=IMG_W-1): set full[wr_bank], toggle wr_bank, clear counters.
- in_sof on an accepted word: counters are forced to (0,0) before that write. Any partial stripe in wr_bank is discarded. full bits and the read side are unaffected.
- Read side:
  - Reads issue from rd_bank while full[rd_bank]=1 and FIFO occupancy + reads in flight < 2.
  - Read address = r*IMG_W + blk*8 + c; counter order is c fastest, then r, then blk.
  - Returned data plus sob/eob/last_block tags enter a 2-entry output FIFO. The FIFO head drives out_*.
- When the read for (blk=IMG_W/8-1, r=7, c=7) issues: clear full[rd_bank], toggle rd_bank, clear read counters.
- Tag rules: out_sob when r=0,c=0; out_eob when r=7,c=7; out_last_block when blk=IMG_W/8-1.
- Setting full[wr_bank] and clearing full[rd_bank] in the same cycle is legal (always different bits). Both updates take effect.
- Output holds stable while out_valid && !out_ready.

## Timing
- Reset values: in_ready=0 during reset and 1 in the first cycle after; out_valid=0, out_sob=0, out_eob=0, out_last_block=0, out_data=0. Counters, banks and full are cleared and the FIFO is emptied. RAM contents are don't-care.
- Reset mid-operation: all partial stripes and in-flight reads are discarded. Outputs return to reset values on the next cycle.
- Latency: if the last stripe word is accepted in cycle t, the first read issues in t+1 and out_valid rises in t+3.
- Throughput: with out_ready held high, 1 word/cycle sustained on both sides, with no bubbles across block or stripe boundaries.
- Backpressure: in_ready falls in the cycle after the second bank becomes full. It rises in the cycle after the reader frees a bank.

## Test plan
- Reset: assert reset 2 cycles -> in_ready=0, out_valid=0 during reset; in_ready=1, out_valid=0 afterwards.
- Ordering, IMG_W=16: write words 0..127 with out_ready=1.
  - Required output: 0..7, 16..23, …, 112..119, then 8..15, 24..31, …, 120..127.
  - out_sob on 0 and 8; out_eob on 119 and 127; out_last_block on the second block only.
  - First out_valid is exactly 3 cycles after accepting word 127.
- Backpressure, IMG_W=16: stream 512 words with random 50% out_ready and random in_valid -> output equals the golden block-order sequence, with no loss or duplication and tags correct.
- Both banks full: with out_ready=0, offer 300 words -> exactly 256 accepted; in_ready=0 from then on; out_valid=1 holding word 0. Raising out_ready drains, and in_ready returns after 128 reads issue.
- Frame resync: write 40 words, then an accepted word with in_sof=1, followed by 127 words, all values from 1000 upward -> output blocks contain only the post-sof 128 words (1040..1167), in block order.
- Mid-read reset: assert reset after 30 outputs of a stripe -> out_valid=0 the next cycle. A freshly written stripe then reads out correctly from word 0.
